// File: rtl/axi_stream_remove_header_if.sv
// ---------------------------------------------------------------------------
// axi_stream_remove_header_if
//
// Purpose:
//   Bundles every handshake and bus signal of the header-stripping block into
//   one interface.
//   The DUT uses the slave modport. The environment that feeds the input
//   stream and the length channel, and drains the header and payload
//   channels, uses the master modport.
//
// Signal summary (DUT view):
//   valid_in / ready_in         in / out   input stream handshake
//   data_in  [DATA_WD]          in         input beat data, byte 0 at MSB
//   keep_in  [DATA_BYTE_WD]     in         input byte enables, MSB-aligned
//   last_in                     in         last beat of input packet
//   valid_len / ready_len       in / out   header-length channel handshake
//   hdr_len  [LEN_WD]           in         header byte count H
//   valid_header / ready_header out / in   extracted-header handshake
//   header_out  [DATA_WD]       out        header bytes, MSB-aligned
//   keep_header [DATA_BYTE_WD]  out        H ones from the MSB
//   valid_out / ready_out       out / in   realigned payload handshake
//   data_out [DATA_WD]          out        payload data, invalid bytes zero
//   keep_out [DATA_BYTE_WD]     out        payload byte enables
//   last_out                    out        last payload beat
//   err_keep                    out        only with STRIP_HDR_ERR_EN defined
// ---------------------------------------------------------------------------
interface axi_stream_remove_header_if #(
   parameter int DATA_WD      = 32,
   parameter int DATA_BYTE_WD = DATA_WD / 8,
   parameter int LEN_WD       = $clog2(DATA_BYTE_WD) + 1
);
   logic                    valid_in;
   logic                    ready_in;
   logic [DATA_WD-1:0]      data_in;
   logic [DATA_BYTE_WD-1:0] keep_in;
   logic                    last_in;
   logic                    valid_len;
   logic                    ready_len;
   logic [LEN_WD-1:0]       hdr_len;
   logic                    valid_header;
   logic                    ready_header;
   logic [DATA_WD-1:0]      header_out;
   logic [DATA_BYTE_WD-1:0] keep_header;
   logic                    valid_out;
   logic                    ready_out;
   logic [DATA_WD-1:0]      data_out;
   logic [DATA_BYTE_WD-1:0] keep_out;
   logic                    last_out;
`ifdef STRIP_HDR_ERR_EN
   logic                    err_keep;
`endif

   modport slave (
      input  valid_in, data_in, keep_in, last_in,
      input  valid_len, hdr_len,
      input  ready_header, ready_out,
      output ready_in, ready_len,
      output valid_header, header_out, keep_header,
      output valid_out, data_out, keep_out, last_out
`ifdef STRIP_HDR_ERR_EN
      , output err_keep
`endif
   );

   modport master (
      output valid_in, data_in, keep_in, last_in,
      output valid_len, hdr_len,
      output ready_header, ready_out,
      input  ready_in, ready_len,
      input  valid_header, header_out, keep_header,
      input  valid_out, data_out, keep_out, last_out
`ifdef STRIP_HDR_ERR_EN
      , input err_keep
`endif
   );
endinterface

// File: rtl/axi_stream_remove_header.sv
// ---------------------------------------------------------------------------
// axi_stream_remove_header
//
// Purpose:
//   Strips an H-byte header (0..DATA_BYTE_WD) from the first beat of every
//   AXI Stream packet.
//   The header is presented on its own channel, and the remaining payload is
//   byte-realigned so that it starts at the MSB of the first output beat.
//   Byte 0 of a beat sits at [DATA_WD-1 -: 8]. keep is MSB-aligned and
//   contiguous.
//
// Ports:
//   clk_i   rising-edge clock
//   rst_i   asynchronous reset, active-high
//   strm    axi_stream_remove_header_if.slave; carries the input stream, the
//           header-length channel, the header channel and the payload stream.
//
// Optional feature macro:
//   STRIP_HDR_ERR_EN  adds err_keep.
//     err_keep is a one-cycle pulse for an accepted beat that has any of:
//       - a non-contiguous keep_in
//       - a non-full keep on a non-last beat
//       - hdr_len > DATA_BYTE_WD
//     hdr_len is then clamped to DATA_BYTE_WD, and keep is taken as its
//     leading-ones count.
// ---------------------------------------------------------------------------
module axi_stream_remove_header #(
   parameter int DATA_WD      = 32,
   parameter int DATA_BYTE_WD = DATA_WD / 8,
   parameter int LEN_WD       = $clog2(DATA_BYTE_WD) + 1
) (
   input logic                       clk_i,
   input logic                       rst_i,
   axi_stream_remove_header_if.slave strm
);

   typedef enum logic [1:0] {IDLE, BODY, FLUSH} state_e;

   state_e                  state_q, state_d;
   logic [LEN_WD-1:0]       hLen_q, hLen_d;
   logic [LEN_WD-1:0]       flushCnt_q, flushCnt_d;
   logic [DATA_WD-1:0]      residue_q, residue_d;
   logic [DATA_WD-1:0]      header_q, header_d;
   logic [DATA_BYTE_WD-1:0] keepHdr_q, keepHdr_d;
   logic                    validHdr_q, validHdr_d;
   logic [DATA_WD-1:0]      dataOut_q, dataOut_d;
   logic [DATA_BYTE_WD-1:0] keepOut_q, keepOut_d;
   logic                    lastOut_q, lastOut_d;
   logic                    validOut_q, validOut_d;

   logic                    slotFree;
   logic                    readyIn;
   logic                    readyLen;
   logic                    beatAcc;
   int                      hIn;
   int                      hCur;
   int                      nIn;
   logic [DATA_WD-1:0]      dataMasked;
   logic [DATA_WD-1:0]      beatData;

   // Number of leading ones in a keep vector; for a legal keep this is the byte count.
   function automatic int leadOnes(input logic [DATA_BYTE_WD-1:0] k);
      int c;
      c = 0;
      for (int i = DATA_BYTE_WD - 1; i >= 0; i--) begin
         if (k[i] && (c == DATA_BYTE_WD - 1 - i)) c = c + 1;
      end
      return c;
   endfunction

   // MSB-aligned keep with k ones; k >= DATA_BYTE_WD gives all ones.
   function automatic logic [DATA_BYTE_WD-1:0] keepOnes(input int k);
      logic [DATA_BYTE_WD-1:0] allOnes;
      allOnes = '1;
      return ~(allOnes >> k);
   endfunction

   // Data mask covering the top k bytes.
   function automatic logic [DATA_WD-1:0] byteMask(input int k);
      logic [DATA_WD-1:0] allOnes;
      allOnes = '1;
      return ~(allOnes >> (8 * k));
   endfunction

   // Decode the incoming beat: byte count, zeroed invalid bytes, and the header length.
   // Out-of-range lengths are clamped only when the error checker is built in.
   always_comb begin
      nIn        = leadOnes(strm.keep_in);
      dataMasked = strm.data_in & byteMask(nIn);
      beatData   = strm.last_in ? dataMasked : strm.data_in;
      hCur       = int'(hLen_q);
      hIn        = int'(strm.hdr_len);
`ifdef STRIP_HDR_ERR_EN
      if (hIn > DATA_BYTE_WD) hIn = DATA_BYTE_WD;
`endif
   end

   // Handshake readiness.
   // The payload register may load when it is empty or is being drained this cycle.
   // In IDLE the first beat and its length are accepted together. This waits until
   // the previous header has been taken.
   // Both readies are forced low while reset is asserted.
   always_comb begin
      slotFree = ~validOut_q | strm.ready_out;
      readyIn  = 1'b0;
      readyLen = 1'b0;
      if (!rst_i) begin
         case (state_q)
            IDLE: begin
               readyIn  = strm.valid_len & ~validHdr_q & slotFree;
               readyLen = readyIn;
            end
            BODY:    readyIn = slotFree;
            default: readyIn = 1'b0;
         endcase
      end
      beatAcc = strm.valid_in & readyIn;
   end

   // State register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic.
   // A last beat with more bytes than the header leaves a residue that needs one extra output beat.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (beatAcc) state_d = strm.last_in ? IDLE : BODY;
         end
         BODY: begin
            if (beatAcc && strm.last_in) state_d = (nIn > hCur) ? FLUSH : IDLE;
         end
         FLUSH: begin
            if (slotFree) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Datapath next values.
   // The residue is kept MSB-aligned. A body output beat is the residue with the
   // top H bytes of the new beat appended below it.
   // With H = DATA_BYTE_WD the residue is empty, so beats pass straight through.
   always_comb begin
      hLen_d     = hLen_q;
      flushCnt_d = flushCnt_q;
      residue_d  = residue_q;
      header_d   = header_q;
      keepHdr_d  = keepHdr_q;
      validHdr_d = validHdr_q & ~strm.ready_header;
      dataOut_d  = dataOut_q;
      keepOut_d  = keepOut_q;
      lastOut_d  = lastOut_q;
      validOut_d = slotFree ? 1'b0 : validOut_q;
      case (state_q)
         IDLE: begin
            if (beatAcc) begin
               hLen_d     = LEN_WD'(hIn);
               header_d   = strm.data_in & byteMask(hIn);
               keepHdr_d  = keepOnes(hIn);
               validHdr_d = 1'b1;
               residue_d  = strm.data_in << (8 * hIn);
               if (strm.last_in && (nIn > hIn)) begin
                  dataOut_d  = dataMasked << (8 * hIn);
                  keepOut_d  = keepOnes(nIn - hIn);
                  lastOut_d  = 1'b1;
                  validOut_d = 1'b1;
               end
            end
         end
         BODY: begin
            if (beatAcc) begin
               validOut_d = 1'b1;
               dataOut_d  = residue_q | (beatData >> (8 * (DATA_BYTE_WD - hCur)));
               if (strm.last_in && (nIn <= hCur)) begin
                  keepOut_d = keepOnes(DATA_BYTE_WD - hCur + nIn);
                  lastOut_d = 1'b1;
               end else begin
                  keepOut_d = '1;
                  lastOut_d = 1'b0;
                  residue_d = beatData << (8 * hCur);
                  if (strm.last_in) flushCnt_d = LEN_WD'(nIn - hCur);
               end
            end
         end
         FLUSH: begin
            if (slotFree) begin
               dataOut_d  = residue_q;
               keepOut_d  = keepOnes(int'(flushCnt_q));
               lastOut_d  = 1'b1;
               validOut_d = 1'b1;
            end
         end
         default: begin
            validOut_d = 1'b0;
         end
      endcase
   end

   // Datapath and output registers; reset clears every output and discards any residue.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         hLen_q     <= '0;
         flushCnt_q <= '0;
         residue_q  <= '0;
         header_q   <= '0;
         keepHdr_q  <= '0;
         validHdr_q <= 1'b0;
         dataOut_q  <= '0;
         keepOut_q  <= '0;
         lastOut_q  <= 1'b0;
         validOut_q <= 1'b0;
      end else begin
         hLen_q     <= hLen_d;
         flushCnt_q <= flushCnt_d;
         residue_q  <= residue_d;
         header_q   <= header_d;
         keepHdr_q  <= keepHdr_d;
         validHdr_q <= validHdr_d;
         dataOut_q  <= dataOut_d;
         keepOut_q  <= keepOut_d;
         lastOut_q  <= lastOut_d;
         validOut_q <= validOut_d;
      end
   end

`ifdef STRIP_HDR_ERR_EN
   logic errKeep_q, errKeep_d;

   // Flag illegal keep patterns or an oversized header length on any accepted beat.
   always_comb begin
      errKeep_d = 1'b0;
      if (beatAcc) begin
         if (strm.keep_in != keepOnes(nIn)) errKeep_d = 1'b1;
         if (!strm.last_in && (strm.keep_in != '1)) errKeep_d = 1'b1;
         if ((state_q == IDLE) && (int'(strm.hdr_len) > DATA_BYTE_WD)) errKeep_d = 1'b1;
      end
   end

   // Register the error flag so it is a clean one-cycle pulse.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) errKeep_q <= 1'b0;
      else       errKeep_q <= errKeep_d;
   end

   assign strm.err_keep = errKeep_q;
`endif

   assign strm.ready_in     = readyIn;
   assign strm.ready_len    = readyLen;
   assign strm.valid_header = validHdr_q;
   assign strm.header_out   = header_q;
   assign strm.keep_header  = keepHdr_q;
   assign strm.valid_out    = validOut_q;
   assign strm.data_out     = dataOut_q;
   assign strm.keep_out     = keepOut_q;
   assign strm.last_out     = lastOut_q;

endmodule
